// File: rtl/hdmi_packet_assembler_if.sv
// Connects the packet picker to the data-island packet assembler. The picker
// holds the header and subpackets for a whole packet and steps on the returned
// pixel counter.
interface hdmi_packet_assembler_if;
    logic             data_island_period;
    logic [23:0]      header;
    logic [3:0][55:0] sub;
    logic [4:0]       packet_pixel_counter;
    logic [8:0]       packet_data;
    logic             packet_data_valid;

    modport master (
        output data_island_period,
        output header,
        output sub,
        input  packet_pixel_counter,
        input  packet_data,
        input  packet_data_valid
    );

    modport slave (
        input  data_island_period,
        input  header,
        input  sub,
        output packet_pixel_counter,
        output packet_data,
        output packet_data_valid
    );
endinterface

// File: rtl/hdmi_packet_assembler.sv
// Serialises one HDMI data-island packet over 32 pixel clocks and appends BCH
// parity (G(x) = 1 + x^6 + x^7 + x^8) to the header and to each subpacket.
module hdmi_packet_assembler (
    input logic                    clk_pixel,
    input logic                    reset_n,
    hdmi_packet_assembler_if.slave bus
);

    function automatic logic [7:0] bch_step(input logic [7:0] e, input logic b);
        return (e >> 1) ^ (((e[0] ^ b) == 1'b1) ? 8'h83 : 8'h00);
    endfunction

    logic [4:0]       pixel_cnt;
    logic [7:0]       hdr_ecc;
    logic [7:0]       hdr_ecc_next;
    logic [3:0][7:0]  sub_ecc;
    logic [3:0][7:0]  sub_ecc_next;
    logic [31:0]      hdr_block;
    logic [3:0][63:0] sub_block;
    logic [5:0]       even_idx;
    logic [5:0]       odd_idx;
    logic [8:0]       pixel_bits;
    logic [8:0]       data_q;
    logic             valid_q;

    assign even_idx = {pixel_cnt, 1'b0};
    assign odd_idx  = {pixel_cnt, 1'b1};

    // The ECC sits in the top bits of each block; once the data bits run out the
    // registers hold, so the same index selects data early and parity late.
    always_comb begin
        hdr_block    = {hdr_ecc, bus.header};
        hdr_ecc_next = hdr_ecc;
        sub_ecc_next = sub_ecc;
        pixel_bits   = '0;

        if (pixel_cnt <= 5'd23) begin
            hdr_ecc_next = bch_step(hdr_ecc, hdr_block[pixel_cnt]);
        end
        pixel_bits[0] = hdr_block[pixel_cnt];

        for (int unsigned i = 0; i < 4; i++) begin
            sub_block[i] = {sub_ecc[i], bus.sub[i]};
            if (pixel_cnt <= 5'd27) begin
                sub_ecc_next[i] = bch_step(bch_step(sub_ecc[i], sub_block[i][even_idx]),
                                           sub_block[i][odd_idx]);
            end
            pixel_bits[1 + i] = sub_block[i][even_idx];
            pixel_bits[5 + i] = sub_block[i][odd_idx];
        end
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            pixel_cnt <= '0;
            hdr_ecc   <= '0;
            sub_ecc   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
        end else if (!bus.data_island_period) begin
            pixel_cnt <= '0;
            hdr_ecc   <= '0;
            sub_ecc   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            pixel_cnt <= pixel_cnt + 5'd1;
            data_q    <= pixel_bits;
            valid_q   <= 1'b1;
            if (pixel_cnt == 5'd31) begin
                hdr_ecc <= '0;
                sub_ecc <= '0;
            end else begin
                hdr_ecc <= hdr_ecc_next;
                sub_ecc <= sub_ecc_next;
            end
        end
    end

    assign bus.packet_pixel_counter = pixel_cnt;
    assign bus.packet_data          = data_q;
    assign bus.packet_data_valid    = valid_q;

endmodule
